wb_dual_writer: RTL

- Writeback-side driver for the 2-write-port register file of the 2-way superscalar core.
- Accepts up to two results per cycle from the two execute lanes and buffers them in order in a small queue.
- Drains up to two queued results per cycle onto the register-file write ports (Wen1/Rd_addr1/write_data1 and Wen2/Rd_addr2/write_data2).
- Guarantees the register file never sees two simultaneous writes to the same rd, and never sees a write to x0.

---
 rtl/wb_dual_writer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_dual_writer.sv
// wb_dual_writer: in-order two-lane result queue draining onto two register-file write ports.
// Optional WB_BYPASS_EN lets results skip an empty queue and load the write ports directly.
module wb_dual_writer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in0_valid,
  input  logic                       in0_we,
  input  logic [AW-1:0]              in0_rd,
  input  logic [XLEN-1:0]            in0_data,
  input  logic                       in1_valid,
  input  logic                       in1_we,
  input  logic [AW-1:0]              in1_rd,
  input  logic [XLEN-1:0]            in1_data,
  output logic                       in_ready,
  input  logic                       wb_stall,
  output logic                       Wen1,
  output logic [AW-1:0]              Rd_addr1,
  output logic [XLEN-1:0]            write_data1,
  output logic                       Wen2,
  output logic [AW-1:0]              Rd_addr2,
  output logic [XLEN-1:0]            write_data2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            q_we   [DEPTH];
  logic [AW-1:0]   q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];

  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d, rp1, wp1;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wen1_q, wen1_d, wen2_q, wen2_d;
  logic [AW-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
  logic [XLEN-1:0] data1_q, data1_d, data2_q, data2_d;

  logic            byp, acc, pop, pop2, e1, e2;
  logic [1:0]      n_push, n_pop;
  logic            c1_v, c1_we, c2_v, c2_we;
  logic [AW-1:0]   c1_rd, c2_rd;
  logic [XLEN-1:0] c1_data, c2_data;

`ifdef WB_BYPASS_EN
  assign byp = (cnt_q == '0) && !wb_stall && !flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready = (cnt_q <= CW'(DEPTH - 2)) && !flush;
  assign acc      = in_ready && !byp;
  assign rp1      = rp_q + PW'(1);
  assign wp1      = wp_q + PW'(1);

  always_comb begin
    n_push  = acc ? {1'b0, in0_valid} + {1'b0, in1_valid} : 2'd0;
    pop     = !wb_stall && (cnt_q != '0);
    pop2    = pop && (cnt_q >= CW'(2));
    n_pop   = {pop2, pop & ~pop2};
    c1_v    = byp ? in0_valid : pop;
    c1_we   = byp ? in0_we    : q_we[rp_q];
    c1_rd   = byp ? in0_rd    : q_rd[rp_q];
    c1_data = byp ? in0_data  : q_data[rp_q];
    c2_v    = byp ? in1_valid : pop2;
    c2_we   = byp ? in1_we    : q_we[rp1];
    c2_rd   = byp ? in1_rd    : q_rd[rp1];
    c2_data = byp ? in1_data  : q_data[rp1];
    e1      = c1_v && c1_we && (c1_rd != '0);
    e2      = c2_v && c2_we && (c2_rd != '0);
    // a same-rd pair keeps only the younger write so the regfile never sees a conflict
    wen1_d  = !flush && e1 && !(e2 && (c1_rd == c2_rd));
    wen2_d  = !flush && e2;
    addr1_d = (c1_v && !flush) ? c1_rd   : addr1_q;
    data1_d = (c1_v && !flush) ? c1_data : data1_q;
    addr2_d = (c2_v && !flush) ? c2_rd   : addr2_q;
    data2_d = (c2_v && !flush) ? c2_data : data2_q;
    cnt_d   = flush ? '0 : cnt_q + CW'(n_push) - CW'(n_pop);
    wp_d    = flush ? '0 : wp_q + PW'(n_push);
    rp_d    = flush ? '0 : rp_q + PW'(n_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      wen1_q  <= 1'b0;
      wen2_q  <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      wen1_q  <= wen1_d;
      wen2_q  <= wen2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && acc && in0_valid) begin
      q_we[wp_q]   <= in0_we;
      q_rd[wp_q]   <= in0_rd;
      q_data[wp_q] <= in0_data;
    end
    if (!flush && acc && in1_valid) begin
      q_we[in0_valid ? wp1 : wp_q]   <= in1_we;
      q_rd[in0_valid ? wp1 : wp_q]   <= in1_rd;
      q_data[in0_valid ? wp1 : wp_q] <= in1_data;
    end
  end

  // upstream must hold results while in_ready is low; a flush legitimately discards them
  always_ff @(posedge clk) begin
    if (rst_n && !flush)
      assert (!((in0_valid || in1_valid) && !in_ready));
  end

  assign Wen1        = wen1_q;
  assign Rd_addr1    = addr1_q;
  assign write_data1 = data1_q;
  assign Wen2        = wen2_q;
  assign Rd_addr2    = addr2_q;
  assign write_data2 = data2_q;
  assign count       = cnt_q;
endmodule
